// File: rtl/aoc3_pkg.sv
// Shared types, ASCII constants and byte classification for the character framer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

package aoc3_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int unsigned DRAIN_CYCLES_DEFAULT = 12;

  typedef enum logic [1:0] {
    StStream,
    StDrain,
    StClear,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ByteDigit,
    ByteCr,
    ByteLf,
    ByteBad
  } byte_class_e;

  function automatic byte_class_e classify_byte(input logic [7:0] b);
    if (b >= ASCII_0 && b <= ASCII_9) begin
      return ByteDigit;
    end else if (b == ASCII_CR) begin
      return ByteCr;
    end else if (b == ASCII_LF) begin
      return ByteLf;
    end
    return ByteBad;
  endfunction

endpackage

// File: rtl/aoc3_char_framer.sv
// Frames an ASCII digit stream into lines: emits digit values, then holds newline for a
// drain window, pulses clear/capture, and counts completed lines until end of file.
module aoc3_char_framer
  import aoc3_pkg::*;
#(
  parameter int unsigned LINE_LENGTH  = 15,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic                   eof,
  output logic [`DATA_WIDTH-1:0] data_in,
  output logic                   data_in_valid,
  output logic                   newline,
  output logic                   line_clear,
  output logic                   line_capture,
  output logic [15:0]            line_count,
  output logic                   bad_char,
  output logic                   len_err,
  output logic                   done
);

  localparam int unsigned CntW   = $clog2(LINE_LENGTH + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [CntW-1:0]   LineLen   = CntW'(LINE_LENGTH);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [CntW-1:0]          char_cnt_q, char_cnt_d;
  logic [DrainW-1:0]        drain_cnt_q, drain_cnt_d;
  logic                     eof_pending_q, eof_pending_d;
  logic [`DATA_WIDTH-1:0]   data_in_q, data_in_d;
  logic                     data_in_valid_q, data_in_valid_d;
  logic [15:0]              line_count_q, line_count_d;
  logic                     bad_char_q, bad_char_d;
  logic                     len_err_q, len_err_d;
  // Holds byte_ready low through reset until the first clock edge after release.
  logic                     rdy_en_q;
  logic                     xfer;

  assign xfer = byte_valid && byte_ready;

  // Next-state logic: byte classification in STREAM, drain timing, line close-out.
  always_comb begin
    state_d         = state_q;
    char_cnt_d      = char_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    eof_pending_d   = eof_pending_q;
    data_in_d       = data_in_q;
    data_in_valid_d = 1'b0;
    line_count_d    = line_count_q;
    bad_char_d      = bad_char_q;
    len_err_d       = len_err_q;

    case (state_q)
      StStream: begin
        if (xfer) begin
          // The byte is handled first; eof is remembered and honoured on a later cycle.
          if (eof) eof_pending_d = 1'b1;
          case (classify_byte(byte_in))
            ByteDigit: begin
              if (char_cnt_q < LineLen) begin
                data_in_d       = `DATA_WIDTH'(byte_in - ASCII_0);
                data_in_valid_d = 1'b1;
                char_cnt_d      = char_cnt_q + CntW'(1);
              end else begin
                len_err_d = 1'b1;
              end
            end
            ByteCr: ;
            ByteLf: begin
              if (char_cnt_q != '0) begin
                if (char_cnt_q != LineLen) len_err_d = 1'b1;
                state_d     = StDrain;
                drain_cnt_d = '0;
              end
            end
            ByteBad: bad_char_d = 1'b1;
          endcase
        end else if (eof || eof_pending_q) begin
          eof_pending_d = 1'b1;
          if (char_cnt_q != '0) begin
            // Unterminated last line: close it as if a newline had arrived.
            if (char_cnt_q != LineLen) len_err_d = 1'b1;
            state_d     = StDrain;
            drain_cnt_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          state_d = StClear;
        end else begin
          drain_cnt_d = drain_cnt_q + DrainW'(1);
        end
      end
      StClear: begin
        line_count_d = line_count_q + 16'd1;
        char_cnt_d   = '0;
        state_d      = eof_pending_q ? StDone : StStream;
      end
      StDone: ;
      default: state_d = StStream;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StStream;
      char_cnt_q      <= '0;
      drain_cnt_q     <= '0;
      eof_pending_q   <= 1'b0;
      data_in_q       <= '0;
      data_in_valid_q <= 1'b0;
      line_count_q    <= '0;
      bad_char_q      <= 1'b0;
      len_err_q       <= 1'b0;
      rdy_en_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      char_cnt_q      <= char_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      eof_pending_q   <= eof_pending_d;
      data_in_q       <= data_in_d;
      data_in_valid_q <= data_in_valid_d;
      line_count_q    <= line_count_d;
      bad_char_q      <= bad_char_d;
      len_err_q       <= len_err_d;
      rdy_en_q        <= 1'b1;
    end
  end

  // Outputs decoded from state so reset clears them immediately.
  always_comb begin
    byte_ready    = rdy_en_q && (state_q == StStream);
    newline       = (state_q == StDrain) || (state_q == StClear);
    line_clear    = (state_q == StClear);
    line_capture  = (state_q == StClear);
    done          = (state_q == StDone);
    data_in       = data_in_q;
    data_in_valid = data_in_valid_q;
    line_count    = line_count_q;
    bad_char      = bad_char_q;
    len_err       = len_err_q;
  end

endmodule

// File: tb/tb_aoc3_char_framer.sv
// Scoreboard bench for aoc3_char_framer: a line-level reference model fills expectation
// queues as bytes are accepted; a monitor pops and compares as the DUT emits.
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

module tb_aoc3_char_framer;

  localparam int LL = 15;
  localparam int DC = 12;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic [7:0]             byte_in = 8'h00;
  logic                   byte_valid = 1'b0;
  logic                   byte_ready;
  logic                   eof = 1'b0;
  logic [`DATA_WIDTH-1:0] data_in;
  logic                   data_in_valid;
  logic                   newline;
  logic                   line_clear;
  logic                   line_capture;
  logic [15:0]            line_count;
  logic                   bad_char;
  logic                   len_err;
  logic                   done;

  aoc3_char_framer #(
    .LINE_LENGTH (LL),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .eof          (eof),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .newline      (newline),
    .line_clear   (line_clear),
    .line_capture (line_capture),
    .line_count   (line_count),
    .bad_char     (bad_char),
    .len_err      (len_err),
    .done         (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int exp_digits[$];
  int exp_caps[$];
  int m_cnt;
  int m_lines;
  bit m_bad;
  bit m_len;
  bit m_done;

  // Monitor-side observations.
  int nl_run;
  int nl_cycles;
  int dv_count;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic void model_reset();
    exp_digits.delete();
    exp_caps.delete();
    m_cnt = 0;
    m_lines = 0;
    m_bad = 0;
    m_len = 0;
    m_done = 0;
    nl_run = 0;
    nl_cycles = 0;
    dv_count = 0;
  endfunction

  function automatic void model_line_end();
    if (m_cnt != LL) m_len = 1;
    exp_caps.push_back(m_lines);
    m_lines = (m_lines + 1) % 65536;
    m_cnt = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) begin
      if (m_cnt < LL) begin
        exp_digits.push_back(int'(b) - 48);
        m_cnt++;
      end else begin
        m_len = 1;
      end
    end else if (b == 8'h0D) begin
      m_cnt = m_cnt;
    end else if (b == 8'h0A) begin
      if (m_cnt > 0) model_line_end();
    end else begin
      m_bad = 1;
    end
  endfunction

  function automatic void model_eof();
    if (m_cnt > 0) model_line_end();
    m_done = 1;
  endfunction

  // Monitor: compare every emitted digit and every line capture against the queues.
  always @(negedge clock) begin
    if (reset_n) begin
      if (data_in_valid) begin
        dv_count++;
        if (exp_digits.size() == 0) fail_now("unexpected_digit");
        else chk("digit", int'(data_in), exp_digits.pop_front());
      end
      if (newline) begin
        nl_run++;
        nl_cycles++;
      end else begin
        nl_run = 0;
      end
      if (line_capture) begin
        chk("clear_with_capture", int'(line_clear), 1);
        chk("newline_run_at_capture", nl_run, DC + 1);
        if (exp_caps.size() == 0) fail_now("unexpected_capture");
        else chk("capture_line_count", int'(line_count), exp_caps.pop_front());
      end
    end
  end

  task automatic assert_reset();
    byte_valid = 1'b0;
    eof = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("outputs_in_reset",
        int'({data_in, data_in_valid, newline, line_clear, line_capture, line_count,
              bad_char, len_err, done, byte_ready}), 0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("ready_after_release", int'(byte_ready), 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 0;
    byte_in = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (byte_ready) begin
        acc = 1;
        break;
      end
    end
    if (!acc) begin
      fail_now("send_timeout");
    end else begin
      @(posedge clock);
      #1;
      model_byte(b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic eof_and_wait();
    bit seen = 0;
    byte_valid = 1'b0;
    eof = 1'b1;
    model_eof();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_reached", int'(seen), 1);
    chk("ready_in_done", int'(byte_ready), 0);
  endtask

  task automatic final_check(input string tag);
    idle(DC + 6);
    chk({tag, "_line_count"}, int'(line_count), m_lines);
    chk({tag, "_bad_char"}, int'(bad_char), int'(m_bad));
    chk({tag, "_len_err"}, int'(len_err), int'(m_len));
    chk({tag, "_done"}, int'(done), int'(m_done));
    chk({tag, "_digits_left"}, exp_digits.size(), 0);
    chk({tag, "_captures_left"}, exp_caps.size(), 0);
  endtask

  initial begin
    bit nl_seen;
    model_reset();
    #12;
    assert_reset();
    release_reset();

    // Full-length line, valid held high throughout.
    send_str("987654321111111\n");
    final_check("t1");
    chk("t1_pulses", dv_count, 15);
    chk("t1_newline_cycles", nl_cycles, DC + 1);

    // Short line with a bad character.
    assert_reset();
    release_reset();
    send_str("12a3\n");
    final_check("t2");
    chk("t2_pulses", dv_count, 3);

    // Empty lines only, then end of file.
    assert_reset();
    release_reset();
    send_str("\n\n");
    eof_and_wait();
    final_check("t3");
    chk("t3_newline_cycles", nl_cycles, 0);

    // Unterminated full line closed by eof.
    assert_reset();
    release_reset();
    send_str("123456789012345");
    eof_and_wait();
    final_check("t4");

    // Reset during drain cycle 5 abandons the line.
    assert_reset();
    release_reset();
    send_str("111111111111111\n");
    nl_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (newline) begin
        nl_seen = 1;
        break;
      end
    end
    chk("t5_drain_started", int'(nl_seen), 1);
    repeat (4) @(negedge clock);
    #1;
    assert_reset();
    release_reset();
    final_check("t5");

    // Overlong line: 16th digit dropped.
    assert_reset();
    release_reset();
    send_str("1234567890123456\n");
    final_check("t6");
    chk("t6_pulses", dv_count, 15);

    // Randomized lines with CR, bad characters, varied lengths and valid gaps.
    assert_reset();
    release_reset();
    for (int ln = 0; ln < 30; ln++) begin
      int len;
      len = $urandom_range(0, 17);
      for (int c = 0; c < len; c++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 85) send_byte(8'(8'h30 + $urandom_range(0, 9)));
        else if (r < 92) send_byte(8'h0D);
        else send_byte(8'($urandom_range(8'h41, 8'h7a)));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      send_byte(8'h0A);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    for (int c = 0; c < int'($urandom_range(0, 5)); c++) send_byte(8'(8'h30 + $urandom_range(0, 9)));
    eof_and_wait();
    final_check("t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
